// File: rtl/sr_drive_ctrl.sv
// Set/clear sequencer for an SR flop: fixed-width s/r pulses, q check, then gap; PULSE_CYCLES+2+GAP_CYCLES per command.
// cmd_ready is high only in IDLE; redundant commands retire in one cycle with no pulse.
module sr_drive_ctrl #(
    parameter int PULSE_CYCLES   = 2,
    parameter int GAP_CYCLES     = 1,
    parameter bit SKIP_REDUNDANT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic       cmd_op,
    output logic       cmd_ready,
    output logic       s,
    output logic       r,
    input  logic       q_fb,
    output logic       exp_q,
    output logic       busy,
    output logic       err_mismatch,
    output logic [7:0] cmd_count
);

    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_PULSE,
        ST_CHECK,
        ST_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic            op_q, op_d;
    logic            s_q, s_d;
    logic            r_q, r_d;
    logic            expst_q, expst_d;
    logic            err_q, err_d;
    logic [7:0]      count_q, count_d;
    logic            hs;

    assign cmd_ready    = (state_q == ST_IDLE) && !rst;
    assign hs           = cmd_valid && cmd_ready;
    assign busy         = (state_q != ST_IDLE);
    assign s            = s_q;
    assign r            = r_q;
    assign exp_q        = expst_q;
    assign err_mismatch = err_q;
    assign cmd_count    = count_q;

    // s/r are registered from the next-state decision, so a pulse starts the cycle after the handshake.
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        gcnt_d  = gcnt_q;
        op_d    = op_q;
        s_d     = 1'b0;
        r_d     = 1'b0;
        expst_d = expst_q;
        err_d   = err_q;
        count_d = count_q;
        case (state_q)
            ST_INIT: begin
                if (pcnt_q == PW'(PULSE_CYCLES)) begin
                    state_d = ST_CHECK;
                    pcnt_d  = '0;
                    expst_d = 1'b0;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                    r_d    = 1'b1;
                end
            end
            ST_IDLE: begin
                if (hs) begin
                    count_d = count_q + 8'd1;
                    if (!(SKIP_REDUNDANT && (cmd_op == expst_q))) begin
                        op_d    = cmd_op;
                        state_d = ST_PULSE;
                        pcnt_d  = PW'(1);
                        s_d     = cmd_op;
                        r_d     = !cmd_op;
                    end
                end
            end
            ST_PULSE: begin
                if (pcnt_q == PW'(PULSE_CYCLES)) begin
                    state_d = ST_CHECK;
                    pcnt_d  = '0;
                    expst_d = op_q;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                    s_d    = op_q;
                    r_d    = !op_q;
                end
            end
            ST_CHECK: begin
                if (q_fb != expst_q) begin
                    err_d = 1'b1;
                end
                if (GAP_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                    gcnt_d  = GW'(1);
                end
            end
            ST_GAP: begin
                if (gcnt_q == GW'(GAP_CYCLES)) begin
                    state_d = ST_IDLE;
                    gcnt_d  = '0;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            pcnt_q  <= '0;
            gcnt_q  <= '0;
            op_q    <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            expst_q <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            gcnt_q  <= gcnt_d;
            op_q    <= op_d;
            s_q     <= s_d;
            r_q     <= r_d;
            expst_q <= expst_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Bench for sr_drive_ctrl: commands push expected outcomes to a scoreboard; a monitor pops on each handshake.
module tb_sr_drive_ctrl;
    localparam int P = 2;
    localparam int G = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_op;
    logic       cmd_ready;
    logic       s;
    logic       r;
    logic       q_fb;
    logic       exp_q;
    logic       busy;
    logic       err_mismatch;
    logic [7:0] cmd_count;

    sr_drive_ctrl #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .SKIP_REDUNDANT(1'b1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .s(s), .r(r), .q_fb(q_fb), .exp_q(exp_q),
        .busy(busy), .err_mismatch(err_mismatch), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    // Un-reset SR flop driven by the DUT; starts at 1 so INIT has something to clear.
    bit ff_q = 1'b1;
    bit force_q0 = 1'b0;
    always @(posedge clk) begin
        if (s) ff_q <= 1'b1;
        else if (r) ff_q <= 1'b0;
    end
    assign q_fb = force_q0 ? 1'b0 : ff_q;

    typedef struct {
        bit       skip;
        bit       op;
        bit       exp_after;
        bit       err_after;
        bit [7:0] cnt_after;
    } item_t;

    item_t    sb[$];
    item_t    mit;
    int       checks = 0;
    int       errors = 0;
    bit       m_exp = 1'b0;
    bit       m_err = 1'b0;
    bit [7:0] m_cnt = 8'd0;
    bit       mon_en = 1'b0;
    bit       mon_busy = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic void model_reset();
        m_exp = 1'b0;
        m_err = 1'b0;
        m_cnt = 8'd0;
    endfunction

    task automatic issue(input bit op);
        item_t it;
        int n;
        it.skip = (op == m_exp);
        it.op   = op;
        if (!it.skip) begin
            m_exp = op;
            if (force_q0 && m_exp) m_err = 1'b1;
        end
        m_cnt++;
        it.exp_after = m_exp;
        it.err_after = m_err;
        it.cnt_after = m_cnt;
        sb.push_back(it);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        n = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 100) begin
                chk("handshake_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic drop();
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || mon_busy || !cmd_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", (n < 200), 1);
    endtask

    // Called right after rst is released: the next negedge is the first INIT cycle.
    task automatic check_init();
        @(negedge clk);
        chk("rst_s", s, 0);
        chk("rst_r", r, 0);
        chk("rst_exp_q", exp_q, 0);
        chk("rst_err", err_mismatch, 0);
        chk("rst_count", cmd_count, 0);
        chk("rst_busy", busy, 1);
        chk("rst_ready", cmd_ready, 0);
        for (int k = 1; k <= P + 2 + G; k++) begin
            @(negedge clk);
            chk("init_r", r, (k <= P) ? 1 : 0);
            chk("init_s", s, 0);
            chk("init_ready", cmd_ready, (k == P + 2 + G) ? 1 : 0);
        end
        chk("init_exp_q", exp_q, 0);
        chk("init_err", err_mismatch, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (mon_en && !rst && cmd_valid && cmd_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                    break;
                end
                mit = sb.pop_front();
                mon_busy = 1'b1;
                if (mit.skip) begin
                    @(negedge clk);
                    chk("skip_ready", cmd_ready, 1);
                    chk("skip_sr", {s, r}, 0);
                    chk("skip_count", cmd_count, mit.cnt_after);
                end else begin
                    for (int k = 1; k <= P; k++) begin
                        @(negedge clk);
                        chk("pulse_s", s, mit.op);
                        chk("pulse_r", r, !mit.op);
                        chk("pulse_ready", cmd_ready, 0);
                        if (k == 1) chk("count_inc", cmd_count, mit.cnt_after);
                    end
                    @(negedge clk);
                    chk("check_sr", {s, r}, 0);
                    chk("check_exp_q", exp_q, mit.exp_after);
                    chk("check_busy", busy, 1);
                    for (int k = 0; k < G; k++) begin
                        @(negedge clk);
                        chk("gap_ready", cmd_ready, 0);
                        chk("gap_sr", {s, r}, 0);
                    end
                    @(negedge clk);
                    chk("ready_back", cmd_ready, 1);
                    chk("err_flag", err_mismatch, mit.err_after);
                    chk("done_count", cmd_count, mit.cnt_after);
                end
                mon_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("s_r_exclusive", (s && r) ? 1 : 0, 0);
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", cmd_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check_init();

        mon_en = 1'b1;
        issue(1'b1); drop();
        issue(1'b1); drop();
        issue(1'b0); issue(1'b1); issue(1'b0); drop();

        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                drop();
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end
        drop();
        wait_idle();

        if (m_exp) begin
            issue(1'b0); drop();
            wait_idle();
        end
        force_q0 = 1'b1;
        issue(1'b1); drop();
        wait_idle();
        force_q0 = 1'b0;
        issue(1'b0); issue(1'b1); drop();
        wait_idle();
        chk("err_sticky", err_mismatch, 1);

        // Clear command interrupted by reset during its second pulse cycle.
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!cmd_ready && n < 100);
            chk("abort_handshake", cmd_ready, 1);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_r_cycle1", r, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_r_cycle2", r, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check_init();

        mon_en = 1'b1;
        for (int i = 0; i < 256; i++) issue(1'b0);
        drop();
        wait_idle();
        chk("count_wrap", cmd_count, 0);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
